// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: a Moore FSM that sequences one instruction over several cycles.
// It drives the datapath selects and write strobes, and keeps a sticky illegal-instruction flag and a retired-instruction counter.
//
// state      | meaning
// -----------+-----------------------------------------------
// FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE     | classify op, ALUOut <= OldPC + imm
// MEMADR     | ALUOut <= rs1 + imm (lw/sw address)
// MEMREAD    | read data memory at ALUOut
// MEMWB      | rd <= Data
// MEMWRITE   | write data memory at ALUOut until mem_ready
// EXECUTER   | ALUOut <= rs1 op rs2
// EXECUTEI   | ALUOut <= rs1 op imm
// ALUWB      | rd <= ALUOut
// BRANCH     | compare rs1/rs2, PC <= ALUOut if taken
// JALR_ADR   | ALUOut <= rs1 + imm (jalr target)
// JAL        | PC <= ALUOut, ALUOut <= OldPC + 4
// LUI        | ALUOut <= 0 + imm
// ILLEGAL    | trap, absorbing until reset
module multicycle_control_unit #(
    parameter bit MEM_STALL = 1'b1,
    parameter bit BNE_EN    = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [2:0]       alu_control,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_src,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
        S_EXECUTEI, S_ALUWB, S_BRANCH, S_JALR_ADR, S_JAL, S_LUI, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic       rdy;
    logic       funct_ok;
    logic       branch_ok;
    logic [2:0] alu_funct;
    logic       unused_instr_bits;

    assign op   = instr[6:0];
    assign f3   = instr[14:12];
    assign f7b5 = instr[30];
    assign rdy  = (MEM_STALL != 1'b0) ? mem_ready : 1'b1;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign funct_ok  = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
                       (f3 == 3'b110) || (f3 == 3'b111);
    assign branch_ok = (f3 == 3'b000) || ((BNE_EN != 1'b0) && (f3 == 3'b001));

    // Only R-type can subtract; addi with instr[30] set is still an add.
    always_comb begin
        alu_funct = 3'b000;
        case (f3)
            3'b000:  alu_funct = (op == OP_REG && f7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_funct = 3'b101;
            3'b100:  alu_funct = 3'b100;
            3'b110:  alu_funct = 3'b011;
            3'b111:  alu_funct = 3'b010;
            default: alu_funct = 3'b000;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE:  imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            OP_LUI:    imm_src = 3'b100;
            default:   imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_control = 3'b000;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        reg_write   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = rdy;
                pc_write   = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = (f3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
                    OP_REG:    state_d = funct_ok ? S_EXECUTER : S_ILLEGAL;
                    OP_IMM:    state_d = funct_ok ? S_EXECUTEI : S_ILLEGAL;
                    OP_BRANCH: state_d = branch_ok ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR_ADR;
                    OP_LUI:    state_d = S_LUI;
                    default:   state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (rdy) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = alu_funct;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_funct;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                pc_write    = f3[0] ? ~zero : zero;
                state_d     = S_FETCH;
            end
            S_JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    // An instruction retires on the edge that returns to FETCH; ILLEGAL never does.
    always_comb begin
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
        instret_d = instret_q;
        if (state_d == S_FETCH && state_q != S_FETCH) instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle RV32I controller, successor to the single-cycle control unit.
- Moore FSM sequences fetch/decode/execute/writeback over a shared memory port and a single ALU, and generates datapath selects and write strobes per cycle.
- Adds the following over the single-cycle unit:
  - memory wait-state handshake;
  - optional BNE;
  - illegal-instruction trap;
  - retired-instruction counter.
- Sits between the instruction register / ALU zero flag and the multicycle datapath.

Parameters:
- MEM_STALL, 1: 1 = honour mem_ready; 0 = mem_ready ignored, treated as 1.
- BNE_EN, 1: 1 = funct3=001 branch (bne) supported; 0 = bne is illegal.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instr  in  32  instruction register contents (valid from DECODE onward)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load strobe
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  IR and OldPC load strobe
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_control  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
- alu_src_b  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- reg_write  out  1  register file write strobe
- illegal  out  1  sticky trap flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (sampled on the clk edge with rst_n=0):
  - state <= FETCH; illegal <= 0; instret <= 0.
  - While rst_n=0, pc_write, ir_write, mem_write and reg_write are forced to 0.
  - All other outputs are don't-care while rst_n=0.
  - Reset mid-instruction abandons the instruction with no strobe.
- Decode fields: op = instr[6:0], f3 = instr[14:12], f7b5 = instr[30].
- Unlisted outputs are 0 in each state. imm_src is driven from op in every state.
- States and outputs:
  - FETCH: adr_src=0, A=00, B=10, add, result_src=10. ir_write = pc_write = mem_ready.
  - DECODE: A=01, B=01, add (computes branch/jal target into ALUOut).
  - MEMADR: A=10, B=01, add.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1; mem_write=1 held until mem_ready.
  - EXECUTER: A=10, B=00, funct decode.
  - EXECUTEI: A=10, B=01, funct decode.
  - ALUWB: result_src=00, reg_write=1.
  - BRANCH: A=10, B=00, sub, result_src=00. pc_write = zero for beq, ~zero for bne.
  - JALR_ADR: A=10, B=01, add.
  - JAL: A=01, B=10, add, result_src=00, pc_write=1.
  - LUI: A=11, B=01, add.
  - ILLEGAL: all strobes 0; illegal=1.
- Transitions:
  - FETCH -> DECODE on mem_ready; FETCH holds otherwise.
  - DECODE by op:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR_ADR
    - 0110111 -> LUI
    - else -> ILLEGAL
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD -> MEMWB on mem_ready; holds otherwise. MEMWB -> FETCH.
  - MEMWRITE -> FETCH on mem_ready; holds otherwise.
  - EXECUTER, EXECUTEI, LUI -> ALUWB. ALUWB -> FETCH.
  - JALR_ADR -> JAL. JAL -> ALUWB (writes OldPC+4 to rd).
  - BRANCH -> FETCH.
  - ILLEGAL is absorbing until reset.
- Funct decode (R-type and I-type):
  - 000: add; sub only if R-type and f7b5=1.
  - 010: slt. 100: xor. 110: or. 111: and.
  - Other f3 -> ILLEGAL, decided in DECODE.
  - Branch f3 other than 000 (or 001 with BNE_EN=1) -> ILLEGAL.
  - lw and sw require f3=010, else ILLEGAL.
- Latency in cycles with mem_ready held at 1: R, I, lui, jal = 4; lw, jalr = 5; sw = 4; beq/bne = 3. Each wait cycle adds one.
- instret:
  - Increments by 1 on the final state's exit edge, i.e. the transition into FETCH.
  - Wraps modulo 2^CNT_W.
  - Never increments once in ILLEGAL.

Test Plan:
- add 0x002081B3, mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB.
  - alu_control=000 in EXECUTER; reg_write=1 only in ALUWB.
  - instret 0->1 after 4 cycles.
- sub 0x402081B3 -> alu_control=001 in EXECUTER.
- addi 0x00108093 -> alu_control=000 in EXECUTEI.
- lw 0x0000A103 with mem_ready low for 2 cycles in FETCH and 2 cycles in MEMREAD -> 9 cycles total.
  - ir_write pulses once; result_src=01 and reg_write=1 in MEMWB.
- sw 0x0020A023 with mem_ready=0 for 3 cycles -> mem_write held high 4 cycles; reg_write never 1.
- beq 0x00000063: zero=0 -> pc_write=0 in BRANCH; zero=1 -> pc_write=1. 3 cycles each.
- bne 0x00001063, zero=0:
  - BNE_EN=1 -> pc_write=1 in BRANCH.
  - BNE_EN=0 -> illegal=1 and stays 1; instret frozen; all strobes 0 until rst_n=0.
- jal 0x0000006F -> pc_write=1 in JAL, then reg_write with result_src=00.
- jalr 0x00000067 -> 5 cycles.
- lui 0x00000037 -> alu_src_a=11, imm_src=100.
- Counter wrap: CNT_W=2, run 5 adds -> instret reads 1.
- Reset mid-instruction: rst_n=0 asserted in MEMWRITE -> no mem_write on the next cycle; state FETCH; instret=0.
